// File: rtl/fp32_div_seq.sv
// fp32_div_seq: sequential binary32 divider, radix-2 restoring, one quotient bit per clock
module fp32_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] res,
  output logic        exception,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero,
  output logic        out_valid,
  input  logic        out_ready
);
  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;
  state_t             state;
  logic        [24:0] r;
  logic        [23:0] mb;
  logic        [25:0] q;
  logic        [4:0]  cnt;
  logic               sign;
  logic        [1:0]  spec;
  logic signed [9:0]  e_base;
  logic               a_zero, b_zero, a_inf, b_inf;
  logic        [1:0]  spec_in;
  logic               r_ge;
  logic        [24:0] r_nxt;
  logic        [22:0] man_t;
  logic               guard;
  logic        [23:0] man_r;
  logic signed [9:0]  e_n;
  // operand classification; spec code: 1 exception, 2 divide by zero, 3 zero dividend
  always_comb begin
    a_zero  = a[30:23] == 8'd0;
    b_zero  = b[30:23] == 8'd0;
    a_inf   = a[30:23] == 8'hFF;
    b_inf   = b[30:23] == 8'hFF;
    spec_in = (a_inf | b_inf | (a_zero & b_zero)) ? 2'd1 : b_zero ? 2'd2 : a_zero ? 2'd3 : 2'd0;
  end
  // one restoring step, then normalise and round half away from zero on the guard bit
  always_comb begin
    r_ge  = r >= {1'b0, mb};
    r_nxt = (r_ge ? r - {1'b0, mb} : r) << 1;
    man_t = q[25] ? q[24:2] : q[23:1];
    guard = q[25] ? q[1] : q[0];
    man_r = {1'b0, man_t} + {23'd0, guard};
    e_n   = e_base + (q[25] ? 10'sd127 : 10'sd126) + (man_r[23] ? 10'sd1 : 10'sd0);
  end
  // control FSM with registered result, flags and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      res         <= 32'd0;
      exception   <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
      r           <= 25'd0;
      mb          <= 24'd0;
      q           <= 26'd0;
      cnt         <= 5'd0;
      sign        <= 1'b0;
      spec        <= 2'd0;
      e_base      <= 10'sd0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          sign     <= a[31] ^ b[31];
          spec     <= spec_in;
          r        <= {2'b01, a[22:0]};
          mb       <= {1'b1, b[22:0]};
          e_base   <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]});
          cnt      <= 5'd0;
          state    <= (spec_in != 2'd0) ? DONE : CALC;
        end
        CALC: begin
          r     <= r_nxt;
          q     <= {q[24:0], r_ge};
          cnt   <= cnt + 5'd1;
          state <= (cnt == 5'd25) ? NORM : CALC;
        end
        NORM: begin
          res         <= (e_n >= 10'sd255) ? {sign, 8'hFF, 23'd0} : (e_n <= 10'sd0) ? {sign, 31'd0} : {sign, e_n[7:0], man_r[22:0]};
          overflow    <= e_n >= 10'sd255;
          underflow   <= e_n <= 10'sd0;
          exception   <= 1'b0;
          div_by_zero <= 1'b0;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: if (!out_valid) begin
          res         <= (spec == 2'd1) ? 32'd0 : (spec == 2'd2) ? {sign, 8'hFF, 23'd0} : {sign, 31'd0};
          exception   <= spec == 2'd1;
          div_by_zero <= spec == 2'd2;
          overflow    <= 1'b0;
          underflow   <= 1'b0;
          out_valid   <= 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_div_seq.sv
// tb_fp32_div_seq: vector table plus scoreboard bench for the sequential divider
module tb_fp32_div_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] res;
  logic        exception, overflow, underflow, div_by_zero;
  logic        out_valid;
  logic        out_ready = 1'b1;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[15];

  fp32_div_seq dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .res(res), .exception(exception), .overflow(overflow), .underflow(underflow),
    .div_by_zero(div_by_zero), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int hold);
    vec_t e;
    int   n;
    logic [31:0] held;
    @(negedge clk);
    out_ready = (hold == 0);
    a = v.a;
    b = v.b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    sb.push_back(v);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (hold > 0) begin
      held = res;
      a = 32'h3F800000;
      b = 32'h40000000;
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_res", res, held);
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("latency", n, e.lat);
      chk("res", res, e.res);
      chk("flags", {28'd0, exception, overflow, underflow, div_by_zero}, {28'd0, e.flags});
    end
    @(posedge clk);
    #1;
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int seen;
    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 27};
    vecs[2]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0001, 1};
    vecs[3]  = '{32'h7F800000, 32'h3F800000, 32'h00000000, 4'b1000, 1};
    vecs[4]  = '{32'h00000000, 32'h00000000, 32'h00000000, 4'b1000, 1};
    vecs[5]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0100, 27};
    vecs[6]  = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0010, 27};
    vecs[7]  = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1};
    vecs[8]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 27};
    vecs[9]  = '{32'h3F800000, 32'h7FC00000, 32'h00000000, 4'b1000, 1};
    vecs[10] = '{32'h40000000, 32'h40400000, 32'h3F2AAAAB, 4'b0000, 27};
    vecs[11] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 27};
    vecs[12] = '{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 1};
    vecs[13] = '{32'h40000000, 32'h3F800000, 32'h40000000, 4'b0000, 27};
    vecs[14] = '{32'h3F800000, 32'hC0000000, 32'hBF000000, 4'b0000, 27};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_flags", {28'd0, exception, overflow, underflow, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    foreach (vecs[i]) run(vecs[i], 0);
    run(vecs[0], 5);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("ignored_input_no_out", seen, 0);
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort_no_out", seen, 0);
    chk("sb_drained", sb.size(), 0);
    run(vecs[1], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
